mem_arbiter_2p: RTL
===================

Name: mem_arbiter_2p

Overview:
Two-port arbiter and sequencer for the team's single-port 16x16 register memory (sel/wr/addr/wdata/rdata interface).
- Accepts read/write requests from two independent requesters over a req/ack handshake.
- Grants them round-robin, drives the memory for exactly one access cycle, and returns read data to the winning port.
- Sits between two masters, for example a CPU-side port and a DMA/test port, and the memory instance.

Parameters:
DATA_W, 16, data width of memory and ports
ADDR_W, 4, address width of memory and ports
RD_LAT, 1, cycles from the memory access cycle (sel=1, wr=0) until mem_rdata is valid; legal values >= 1

Ports:
clk  input  1  single clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk
req0  input  1  port 0 request; held high until ack0
wr0  input  1  port 0 direction: 1 = write, 0 = read
addr0  input  ADDR_W  port 0 address
wdata0  input  DATA_W  port 0 write data
ack0  output  1  one-cycle completion pulse for port 0
rdata0  output  DATA_W  port 0 read data
req1, wr1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
mem_sel  output  1  memory select
mem_wr  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (reset=0 at a rising edge): state=IDLE; ack0/ack1=0; rdata0/rdata1=0; latched id/wr/addr/wdata=0; last_gnt=1, so port 0 wins the first tie. Consequently mem_sel=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0.
- Memory outputs:
  - mem_addr and mem_wdata are driven from the latched request registers.
  - mem_sel=1 only in ISSUE; mem_wr = latched wr in ISSUE, else 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
  - IDLE:
    - No req: stay.
    - One req: grant it.
    - Both req: grant the port != last_gnt.
    - On grant: latch id, wr, addr, wdata; last_gnt <= id; go to ISSUE.
  - ISSUE (1 cycle): memory access. If wr, go to ACK. If read, load wait counter with RD_LAT and go to WAIT.
  - WAIT: decrement the counter each cycle. In the cycle the counter is 1, capture mem_rdata into rdata[id] and go to ACK. WAIT lasts exactly RD_LAT cycles.
  - ACK (1 cycle): ack[id]=1, other ack=0. Then go to IDLE.
- Latency from the IDLE grant cycle (cycle 0):
  - Write: mem access in cycle 1, ack in cycle 2.
  - Read: mem access in cycle 1, ack in cycle 2+RD_LAT. With RD_LAT=1, ack is in cycle 3.
  - Minimum spacing between acks is 3 cycles for writes and 3+RD_LAT for reads.
- Handshake:
  - The requester holds req/wr/addr/wdata stable until it samples ack=1.
  - Port inputs are latched at grant, so changes after grant do not affect the in-flight access.
  - req still high in the IDLE cycle after ACK is a new request.
- rdata[x] updates only on a read completion for port x. It is valid in the ack cycle and held until that port's next read completes. Writes never change rdata.
- The losing port is held with no ack; it is guaranteed the next grant while it keeps req asserted (no starvation).
- Reset mid-operation (any state): next cycle IDLE with all reset values. The aborted transaction gets no ack. last_gnt returns to 1.
- There is no error or timeout path. Any addr value 0..2^ADDR_W-1 is passed through unmodified.

Test Plan:
- Hold reset=0 for 2 cycles with req0=req1=1 -> ack0/ack1/mem_sel/busy stay 0 and rdata0/rdata1=0000. First grant after reset=1 goes to port 0.
- Port 0 writes addr=1, wdata=A5A5 -> mem_sel=1, mem_wr=1, mem_addr=1, mem_wdata=A5A5 for exactly one cycle (cycle 1). ack0=1 in cycle 2; ack1 never asserts.
- Port 1 reads addr=1 after the previous write -> one cycle of mem_sel=1, mem_wr=0, mem_addr=1. ack1 in cycle 3 (RD_LAT=1) with rdata1=A5A5; rdata0 unchanged.
- req0 and req1 held continuously: port 0 writes 5A5A to addr 2, port 1 writes 3C3C to addr 3, each re-requesting after ack. Required: acks alternate 0,1,0,1; read-back of addr 2 gives 5A5A and addr 3 gives 3C3C.
- Port 0 read of addr 2 granted, then port 0 changes addr0 to 7 during WAIT -> mem_addr stays 2 and rdata0=5A5A at ack0.
- reset=0 for one cycle during WAIT of a port 1 read -> no ack1, all outputs at reset values next cycle. A subsequent port 1 read of addr 3 completes normally with rdata1=3C3C.

Source files
------------

// File: rtl/mem_arbiter_2p.sv
// Round-robin two-port arbiter/sequencer for a single-port register memory; write acks 2 cycles after grant, read acks 2+RD_LAT cycles after grant.
// The losing requester is held without ack until the winner's ACK cycle; it then wins the next grant.
module mem_arbiter_2p #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_sel,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t           state;
    req_t             cur;
    req_t             port0_req;
    req_t             port1_req;
    logic             id;
    logic             last_gnt;
    logic             gnt_id;
    logic [CNT_W-1:0] cnt;

    assign port0_req = '{wr: wr0, addr: addr0, wdata: wdata0};
    assign port1_req = '{wr: wr1, addr: addr1, wdata: wdata1};

    // On a tie the port that did not win last time is granted.
    assign gnt_id = (req0 && req1) ? ~last_gnt : req1;

    assign mem_addr  = cur.addr;
    assign mem_wdata = cur.wdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cur      <= '0;
            id       <= 1'b0;
            last_gnt <= 1'b1;
            cnt      <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            mem_sel  <= 1'b0;
            mem_wr   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            mem_sel <= 1'b0;
            mem_wr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        id       <= gnt_id;
                        last_gnt <= gnt_id;
                        cur      <= gnt_id ? port1_req : port0_req;
                        mem_sel  <= 1'b1;
                        mem_wr   <= gnt_id ? wr1 : wr0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur.wr) begin
                        ack0  <= ~id;
                        ack1  <= id;
                        state <= ACK;
                    end else begin
                        cnt   <= CNT_W'(RD_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    // Last wait cycle: memory read data is valid now.
                    if (cnt == CNT_W'(1)) begin
                        if (id) rdata1 <= mem_rdata;
                        else    rdata0 <= mem_rdata;
                        ack0  <= ~id;
                        ack1  <= id;
                        state <= ACK;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
